// File: rtl/jogo_pkg.sv
// Shared definitions for the ultimate tic-tac-toe control unit and datapath.
// - estado_t   : 4-bit FSM state codes (0..15), also exported on db_estado.
// - JOGADOR_X/O: player codes used on the datapath side.
// - M_ESPERA   : settle-timer modulus.
// - sinais_t   : bundle of the Moore control strobes, plus their state decoder.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL          = 4'd0,
    PREPARA          = 4'd1,
    ESPERA_MACRO     = 4'd2,
    REGISTRA_MACRO   = 4'd3,
    VALIDA_MACRO     = 4'd4,
    ESPERA_MICRO     = 4'd5,
    REGISTRA_MICRO   = 4'd6,
    VALIDA_MICRO     = 4'd7,
    GRAVA_JOGADA     = 4'd8,
    ESPERA_ATUALIZA  = 4'd9,
    GRAVA_ESTADO     = 4'd10,
    VERIFICA_FIM     = 4'd11,
    TROCA_JOGADOR    = 4'd12,
    VALIDA_PROXIMA   = 4'd13,
    REGISTRA_PROXIMA = 4'd14,
    FIM              = 4'd15
  } estado_t;

  localparam logic [1:0] JOGADOR_X = 2'b01;
  localparam logic [1:0] JOGADOR_O = 2'b10;

  localparam int unsigned M_ESPERA = 32'd5;

  typedef struct packed {
    logic zera_edge;
    logic zera_r_micro;
    logic zera_r_macro;
    logic zera_flip_flop_t;
    logic zera_ram;
    logic registra_r_micro;
    logic registra_r_macro;
    logic sinal_macro;
    logic sinal_valida_macro;
    logic we_board;
    logic we_board_state;
    logic troca_jogador;
    logic conta_t;
    logic zera_t;
    logic pronto;
  } sinais_t;

  // Moore decode: every strobe not named for a state stays low.
  function automatic sinais_t decodifica(estado_t e);
    sinais_t s;
    s = '0;
    case (e)
      PREPARA: begin
        s.zera_edge        = 1'b1;
        s.zera_r_micro     = 1'b1;
        s.zera_r_macro     = 1'b1;
        s.zera_flip_flop_t = 1'b1;
        s.zera_ram         = 1'b1;
        s.zera_t           = 1'b1;
      end
      REGISTRA_MACRO: begin
        s.registra_r_macro = 1'b1;
        s.sinal_macro      = 1'b1;
      end
      VALIDA_MACRO:     s.sinal_valida_macro = 1'b1;
      REGISTRA_MICRO:   s.registra_r_micro   = 1'b1;
      GRAVA_JOGADA:     s.we_board           = 1'b1;
      ESPERA_ATUALIZA:  s.conta_t            = 1'b1;
      GRAVA_ESTADO: begin
        s.we_board_state     = 1'b1;
        s.sinal_valida_macro = 1'b1;
      end
      TROCA_JOGADOR: begin
        s.troca_jogador = 1'b1;
        s.zera_t        = 1'b1;
      end
      // The forced next macro is loaded from the micro register (sinal_macro = 0).
      REGISTRA_PROXIMA: s.registra_r_macro = 1'b1;
      FIM:              s.pronto           = 1'b1;
      default:          s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle.sv
// Moore control unit sequencing one game of ultimate tic-tac-toe.
// Inputs : clock, reset (async active-low), iniciar, tem_jogada, macro_vencida,
//          micro_jogada, fim_jogo, fimT (datapath status flags).
// Outputs: datapath clears (zera*), register enables (registraR_*), mux selects
//          (sinal_macro, sinal_valida_macro), RAM write enables, troca_jogador,
//          settle-timer controls (contaT, zeraT), jogada_invalida, pronto, db_estado.
// Strobes are registered from the next-state decode so they line up with the
// state register; jogada_invalida is the only combinational (state-gated) output.
module unidade_controle
  import jogo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       macro_vencida,
  input  logic       micro_jogada,
  input  logic       fim_jogo,
  input  logic       fimT,
  output logic       zeraEdge,
  output logic       zeraR_micro,
  output logic       zeraR_macro,
  output logic       zeraFlipFlopT,
  output logic       zeraRAM,
  output logic       registraR_micro,
  output logic       registraR_macro,
  output logic       sinal_macro,
  output logic       sinal_valida_macro,
  output logic       we_board,
  output logic       we_board_state,
  output logic       troca_jogador,
  output logic       contaT,
  output logic       zeraT,
  output logic       jogada_invalida,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;
  sinais_t sinais_q, sinais_d;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= INICIAL;
    else        estado_q <= estado_d;
  end

  // Next-state logic; tem_jogada and iniciar are only looked at where they matter.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:          if (iniciar) estado_d = PREPARA;
      PREPARA:          estado_d = ESPERA_MACRO;
      ESPERA_MACRO:     if (tem_jogada) estado_d = REGISTRA_MACRO;
      REGISTRA_MACRO:   estado_d = VALIDA_MACRO;
      VALIDA_MACRO:     estado_d = macro_vencida ? ESPERA_MACRO : ESPERA_MICRO;
      ESPERA_MICRO:     if (tem_jogada) estado_d = REGISTRA_MICRO;
      REGISTRA_MICRO:   estado_d = VALIDA_MICRO;
      VALIDA_MICRO:     estado_d = micro_jogada ? ESPERA_MICRO : GRAVA_JOGADA;
      GRAVA_JOGADA:     estado_d = ESPERA_ATUALIZA;
      ESPERA_ATUALIZA:  if (fimT) estado_d = GRAVA_ESTADO;
      GRAVA_ESTADO:     estado_d = VERIFICA_FIM;
      VERIFICA_FIM:     estado_d = fim_jogo ? FIM : TROCA_JOGADOR;
      TROCA_JOGADOR:    estado_d = VALIDA_PROXIMA;
      // A decided target macro gives the next player a free choice.
      VALIDA_PROXIMA:   estado_d = macro_vencida ? ESPERA_MACRO : REGISTRA_PROXIMA;
      REGISTRA_PROXIMA: estado_d = ESPERA_MICRO;
      FIM:              if (iniciar) estado_d = PREPARA;
      default:          estado_d = INICIAL;
    endcase
  end

  // Decode the strobes for the state about to be entered.
  always_comb begin
    sinais_d = decodifica(estado_d);
  end

  // Output register; cleared together with the state so reset forces all-zero outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sinais_q <= '0;
    else        sinais_q <= sinais_d;
  end

  assign zeraEdge           = sinais_q.zera_edge;
  assign zeraR_micro        = sinais_q.zera_r_micro;
  assign zeraR_macro        = sinais_q.zera_r_macro;
  assign zeraFlipFlopT      = sinais_q.zera_flip_flop_t;
  assign zeraRAM            = sinais_q.zera_ram;
  assign registraR_micro    = sinais_q.registra_r_micro;
  assign registraR_macro    = sinais_q.registra_r_macro;
  assign sinal_macro        = sinais_q.sinal_macro;
  assign sinal_valida_macro = sinais_q.sinal_valida_macro;
  assign we_board           = sinais_q.we_board;
  assign we_board_state     = sinais_q.we_board_state;
  assign troca_jogador      = sinais_q.troca_jogador;
  assign contaT             = sinais_q.conta_t;
  assign zeraT              = sinais_q.zera_t;
  assign pronto             = sinais_q.pronto;
  assign db_estado          = estado_q;

  // Rejection pulse: only the two validation states may flag an invalid move,
  // so it lasts exactly the one cycle spent there.
  assign jogada_invalida = ((estado_q == VALIDA_MACRO) && macro_vencida) ||
                           ((estado_q == VALIDA_MICRO) && micro_jogada);

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: randomized games (waits, rejections,
// ignored pulses, next-macro outcome, game length) driven as directed steps, with
// per-cycle expectations taken from the game rules and a settle-timer model.
module tb_unidade_controle;
  import jogo_pkg::*;

  logic clock = 1'b0;
  logic reset, iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo;
  logic fimT;
  logic zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraRAM;
  logic registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro;
  logic we_board, we_board_state, troca_jogador, contaT, zeraT;
  logic jogada_invalida, pronto;
  logic [3:0] db_estado;

  unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
    .macro_vencida(macro_vencida), .micro_jogada(micro_jogada), .fim_jogo(fim_jogo),
    .fimT(fimT), .zeraEdge(zeraEdge), .zeraR_micro(zeraR_micro),
    .zeraR_macro(zeraR_macro), .zeraFlipFlopT(zeraFlipFlopT), .zeraRAM(zeraRAM),
    .registraR_micro(registraR_micro), .registraR_macro(registraR_macro),
    .sinal_macro(sinal_macro), .sinal_valida_macro(sinal_valida_macro),
    .we_board(we_board), .we_board_state(we_board_state),
    .troca_jogador(troca_jogador), .contaT(contaT), .zeraT(zeraT),
    .jogada_invalida(jogada_invalida), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Output masks (bit positions in obs).
  localparam logic [15:0] ZERAS    = 16'hF804; // zeraEdge..zeraRAM + zeraT
  localparam logic [15:0] R_MICRO  = 16'h0400;
  localparam logic [15:0] R_MACRO  = 16'h0200;
  localparam logic [15:0] S_MACRO  = 16'h0100;
  localparam logic [15:0] S_VALIDA = 16'h0080;
  localparam logic [15:0] WE_B     = 16'h0040;
  localparam logic [15:0] WE_BS    = 16'h0020;
  localparam logic [15:0] TROCA    = 16'h0010;
  localparam logic [15:0] CONTA    = 16'h0008;
  localparam logic [15:0] ZERA_T   = 16'h0004;
  localparam logic [15:0] INVAL    = 16'h0002;
  localparam logic [15:0] PRONTO   = 16'h0001;
  localparam logic [15:0] NADA     = 16'h0000;

  logic [15:0] obs;
  assign obs = {zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraRAM,
                registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
                we_board, we_board_state, troca_jogador, contaT, zeraT,
                jogada_invalida, pronto};

  // Datapath settle timer: cleared by zeraT, counts while contaT, wraps at M_ESPERA.
  int cnt_t = 0;
  always @(posedge clock) begin
    if (zeraT)       cnt_t <= 0;
    else if (contaT) cnt_t <= (cnt_t + 1) % int'(M_ESPERA);
  end
  assign fimT = (cnt_t == int'(M_ESPERA) - 1);

  int n_checks = 0;
  int n_err    = 0;
  int n_inv    = 0;
  int n_troca  = 0;
  int exp_inv  = 0;
  int exp_troca = 0;
  bit need_macro;

  // Event monitor for pulse counts.
  always @(negedge clock) begin
    if (jogada_invalida) n_inv   <= n_inv + 1;
    if (troca_jogador)   n_troca <= n_troca + 1;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Advance one edge and check state code plus all strobes.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] ex);
    @(posedge clock);
    #1;
    chk({tag, "/estado"}, {28'd0, db_estado}, {28'd0, st});
    chk({tag, "/saidas"}, {16'd0, obs}, {16'd0, ex});
  endtask

  // Idle in a wait state with irrelevant inputs toggling.
  task automatic espera(input logic [3:0] st);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      iniciar       = 1'($urandom_range(0, 1));
      macro_vencida = 1'($urandom_range(0, 1));
      micro_jogada  = 1'($urandom_range(0, 1));
      cyc("espera", st, NADA);
    end
    iniciar = 1'b0;
  endtask

  task automatic fase_macro();
    int r;
    espera(4'd2);
    r = $urandom_range(0, 2);
    for (int i = 0; i < r; i++) begin
      tem_jogada = 1'b1;
      cyc("reg_macro", 4'd3, R_MACRO | S_MACRO);
      tem_jogada = 1'b0;
      macro_vencida = 1'b1;
      cyc("rej_macro", 4'd4, S_VALIDA | INVAL);
      exp_inv++;
      cyc("volta_macro", 4'd2, NADA);
    end
    tem_jogada = 1'b1;
    cyc("reg_macro", 4'd3, R_MACRO | S_MACRO);
    tem_jogada = 1'b0;
    macro_vencida = 1'b0;
    cyc("val_macro", 4'd4, S_VALIDA);
    cyc("ok_macro", 4'd5, NADA);
  endtask

  task automatic fase_micro();
    int r;
    espera(4'd5);
    r = $urandom_range(0, 2);
    for (int i = 0; i < r; i++) begin
      tem_jogada = 1'b1;
      cyc("reg_micro", 4'd6, R_MICRO);
      tem_jogada = 1'b0;
      micro_jogada = 1'b1;
      cyc("rej_micro", 4'd7, INVAL);
      exp_inv++;
      cyc("volta_micro", 4'd5, NADA);
    end
    tem_jogada = 1'b1;
    cyc("reg_micro", 4'd6, R_MICRO);
    tem_jogada = 1'b0;
    micro_jogada = 1'b0;
    macro_vencida = 1'b1;  // must not matter outside the validation states
    cyc("val_micro", 4'd7, NADA);
    macro_vencida = 1'b0;
    cyc("grava", 4'd8, WE_B);
  endtask

  task automatic atualiza(input bit ultimo);
    int k;
    bit nv;
    k = $urandom_range(0, 4);
    for (int i = 0; i < 5; i++) begin
      tem_jogada = (i == k);  // stray press, must be discarded
      iniciar    = 1'($urandom_range(0, 1));
      cyc("espera_atualiza", 4'd9, CONTA);
      tem_jogada = 1'b0;
    end
    iniciar = 1'b0;
    cyc("grava_estado", 4'd10, WE_BS | S_VALIDA);
    fim_jogo = ultimo;
    cyc("verifica_fim", 4'd11, NADA);
    if (ultimo) begin
      cyc("fim", 4'd15, PRONTO);
      fim_jogo = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tem_jogada = 1'b1;
        cyc("fim_espera", 4'd15, PRONTO);
        tem_jogada = 1'b0;
      end
      iniciar = 1'b1;
      cyc("reinicia", 4'd1, ZERAS);
      iniciar = 1'b0;
      cyc("pos_reinicia", 4'd2, NADA);
      need_macro = 1'b1;
    end else begin
      fim_jogo = 1'b0;
      cyc("troca", 4'd12, TROCA | ZERA_T);
      exp_troca++;
      nv = 1'($urandom_range(0, 1));
      macro_vencida = nv;
      cyc("valida_proxima", 4'd13, NADA);
      if (nv) begin
        cyc("livre", 4'd2, NADA);
        need_macro = 1'b1;
      end else begin
        cyc("registra_proxima", 4'd14, R_MACRO);
        cyc("forcada", 4'd5, NADA);
        need_macro = 1'b0;
      end
      macro_vencida = 1'b0;
    end
  endtask

  initial begin
    int nm;
    reset = 1'b0; iniciar = 1'b1; tem_jogada = 1'b0;
    macro_vencida = 1'b0; micro_jogada = 1'b0; fim_jogo = 1'b0;
    #2;
    chk("reset/estado", {28'd0, db_estado}, 32'd0);
    chk("reset/saidas", {16'd0, obs}, 32'd0);
    cyc("reset_hold", 4'd0, NADA);
    cyc("reset_hold", 4'd0, NADA);
    reset = 1'b1;
    cyc("prepara", 4'd1, ZERAS);
    iniciar = 1'b0;
    cyc("pos_prepara", 4'd2, NADA);
    need_macro = 1'b1;

    for (int g = 0; g < 2; g++) begin
      nm = (g == 0) ? int'($urandom_range(3, 5)) : 2;
      for (int m = 0; m < nm; m++) begin
        if (need_macro) fase_macro();
        fase_micro();
        atualiza(m == nm - 1);
      end
    end

    // Reset in the middle of the settle wait.
    fase_macro();
    fase_micro();
    cyc("espera_atualiza", 4'd9, CONTA);
    cyc("espera_atualiza", 4'd9, CONTA);
    #2;
    reset = 1'b0;
    #1;
    chk("aborto/estado", {28'd0, db_estado}, 32'd0);
    chk("aborto/saidas", {16'd0, obs}, 32'd0);
    cyc("aborto_hold", 4'd0, NADA);
    reset = 1'b1;
    cyc("inicial_parado", 4'd0, NADA);
    iniciar = 1'b1;
    cyc("prepara2", 4'd1, ZERAS);
    iniciar = 1'b0;
    cyc("pos_prepara2", 4'd2, NADA);

    @(negedge clock);
    chk("conta_invalida", n_inv, exp_inv);
    chk("conta_troca", n_troca, exp_troca);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
